// File: rtl/cba_multicycle_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cba_pkg: shared types and constants for the multicycle carry-bypass adder |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cba_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width; never narrower than one bit, even for a single slice.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cba_multicycle_adder_carry_bypass.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | CarryBypassAdder: 8-bit adder built from two 4-bit carry-bypass groups    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module CarryBypassAdder
  import cba_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int GRP_W = 4;
  localparam int NGRP  = SLICE_W / GRP_W;

  logic w_c;
  logic w_grp_cin;
  logic w_grp_prop;
  logic w_p;

  // A group whose bits all propagate forwards its carry-in directly.
  always_comb begin
    sum        = '0;
    w_c        = cin;
    w_grp_cin  = 1'b0;
    w_grp_prop = 1'b0;
    w_p        = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      w_grp_cin  = w_c;
      w_grp_prop = 1'b1;
      for (int i = 0; i < GRP_W; i++) begin
        w_p                  = a[g*GRP_W+i] ^ b[g*GRP_W+i];
        sum[g*GRP_W+i]       = w_p ^ w_c;
        w_grp_prop           = w_grp_prop & w_p;
        w_c                  = (a[g*GRP_W+i] & b[g*GRP_W+i]) | (w_c & w_p);
      end
      if (w_grp_prop) begin
        w_c = w_grp_cin;
      end
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/cba_multicycle_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cba_multicycle_adder: WIDTH-bit adder reusing one 8-bit slice per cycle   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cba_multicycle_adder
  import cba_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  assign w_slice_a = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
  assign w_slice_b = r_b[int'(r_idx)*SLICE_W +: SLICE_W];

  CarryBypassAdder u_slice (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          sum[int'(r_idx)*SLICE_W +: SLICE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            cout      <= w_slice_cout;
            ovf       <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice_sum[SLICE_W-1] ^ w_slice_cout;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
